// File: rtl/reg_access_arbiter_if.sv
// Bus bundle between the control agents and the shared-register arbiter.
// Build option ARB_LOCK_EN adds the per-requester req_lock input.
interface reg_access_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IDXW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_data;
`ifdef ARB_LOCK_EN
    logic [NREQ-1:0]       req_lock;
`endif
    logic [NREQ-1:0]       req_ack;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [WIDTH-1:0]      q;
    logic [IDXW-1:0]       last_owner;

`ifdef ARB_LOCK_EN
    modport master (
        output req_valid, req_op, req_data, req_lock,
        input  req_ack, grant, busy, q, last_owner
    );

    modport slave (
        input  req_valid, req_op, req_data, req_lock,
        output req_ack, grant, busy, q, last_owner
    );
`else
    modport master (
        output req_valid, req_op, req_data,
        input  req_ack, grant, busy, q, last_owner
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ack, grant, busy, q, last_owner
    );
`endif
endinterface

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter/sequencer sharing one WIDTH-bit register among NREQ
// requesters. Each granted request runs IDLE -> EXEC -> DONE (3 cycles).
// Build option ARB_LOCK_EN: an owner holding req_lock during DONE keeps
// the grant for as long as it stays valid.
module reg_access_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 aclr,
    reg_access_arbiter_if.slave bus
);
    localparam int              IDXW     = $clog2(NREQ);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_PRESET = 2'b10,
        OP_READ   = 2'b11
    } op_t;

    state_t           state, state_next;
    logic [IDXW-1:0]  ptr, ptr_next;
    logic [IDXW-1:0]  owner, owner_next;
    logic [IDXW-1:0]  last, last_next;
    op_t              op, op_next;
    logic [WIDTH-1:0] data, data_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [NREQ-1:0]  grant_reg, grant_next;
    logic [NREQ-1:0]  ack_reg, ack_next;
    logic             busy_reg, busy_next;

    logic             rr_found;
    logic [IDXW-1:0]  rr_winner;
    logic [IDXW-1:0]  cand_idx;
    int               cand;
    logic             pick_found;
    logic [IDXW-1:0]  pick_idx;

`ifdef ARB_LOCK_EN
    logic             locked, locked_next;
    logic             lock_hold;
`endif

    // Round-robin search: first valid requester after ptr, wrapping modulo NREQ.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDXW'(cand);
            if (!rr_found && bus.req_valid[cand_idx]) begin
                rr_found  = 1'b1;
                rr_winner = cand_idx;
            end
        end
    end

    // Final winner selection; a held lock overrides the round-robin choice.
    always_comb begin
        pick_found = rr_found;
        pick_idx   = rr_winner;
`ifdef ARB_LOCK_EN
        lock_hold  = locked && bus.req_valid[owner];
        if (lock_hold) begin
            pick_found = 1'b1;
            pick_idx   = owner;
        end
`endif
    end

    // Next-state and registered-output logic for the IDLE/EXEC/DONE sequence.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        owner_next = owner;
        last_next  = last;
        op_next    = op;
        data_next  = data;
        q_next     = q_reg;
        grant_next = grant_reg;
        ack_next   = ack_reg;
        busy_next  = busy_reg;
`ifdef ARB_LOCK_EN
        locked_next = locked;
`endif
        case (state)
            IDLE: begin
                grant_next = '0;
`ifdef ARB_LOCK_EN
                if (!lock_hold) begin
                    locked_next = 1'b0;
                end
`endif
                if (pick_found) begin
                    owner_next = pick_idx;
                    op_next    = op_t'(bus.req_op[2*int'(pick_idx) +: 2]);
                    data_next  = bus.req_data[WIDTH*int'(pick_idx) +: WIDTH];
                    grant_next = ONE_HOT0 << pick_idx;
                    busy_next  = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                case (op)
                    OP_LOAD:   q_next = data;
                    OP_CLEAR:  q_next = '0;
                    OP_PRESET: q_next = '1;
                    default:   q_next = q_reg;
                endcase
                ack_next   = ONE_HOT0 << owner;
                state_next = DONE;
            end
            DONE: begin
                ptr_next   = owner;
                last_next  = owner;
                grant_next = '0;
                ack_next   = '0;
                busy_next  = 1'b0;
                state_next = IDLE;
`ifdef ARB_LOCK_EN
                locked_next = bus.req_lock[owner];
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; aclr aborts any transaction in flight.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state     <= IDLE;
            ptr       <= LAST_IDX;
            owner     <= LAST_IDX;
            last      <= LAST_IDX;
            op        <= OP_READ;
            data      <= '0;
            q_reg     <= '0;
            grant_reg <= '0;
            ack_reg   <= '0;
            busy_reg  <= 1'b0;
`ifdef ARB_LOCK_EN
            locked    <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            owner     <= owner_next;
            last      <= last_next;
            op        <= op_next;
            data      <= data_next;
            q_reg     <= q_next;
            grant_reg <= grant_next;
            ack_reg   <= ack_next;
            busy_reg  <= busy_next;
`ifdef ARB_LOCK_EN
            locked    <= locked_next;
`endif
        end
    end

    assign bus.q          = q_reg;
    assign bus.grant      = grant_reg;
    assign bus.req_ack    = ack_reg;
    assign bus.busy       = busy_reg;
    assign bus.last_owner = last;

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit register among NREQ requesters.
- Each requester issues one of four operations: load, synchronous clear, synchronous preset, or no-op read.
- The block grants one requester at a time, applies the latched operation to the shared register, and returns a one-cycle acknowledge.
- It sits between control agents and a shared status/config register in the datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, width of the shared register.
- IDXW, $clog2(NREQ), width of the owner index; derived localparam, not overridable.

Ports:
- clk  input  1  clock, rising edge.
- aclr  input  1  reset, asynchronous, active-high.
- req_valid  input  NREQ  request pending, one bit per requester.
- req_op  input  2*NREQ  op of requester i at [2i+1:2i]: 00 load, 01 clear, 10 preset, 11 no-op read.
- req_data  input  WIDTH*NREQ  load data of requester i at [WIDTH*i +: WIDTH].
- req_ack  output  NREQ  one-hot, one-cycle completion pulse.
- grant  output  NREQ  one-hot current owner; 0 when idle.
- busy  output  1  high in EXEC and DONE.
- q  output  WIDTH  shared register value.
- last_owner  output  IDXW  index of the most recently completed requester.

Behaviour:
- Reset (aclr high, asynchronous, dominates clk):
  - q=0, req_ack=0, grant=0, busy=0, last_owner=NREQ-1.
  - state=IDLE, round-robin pointer ptr=NREQ-1.
- FSM states: IDLE, EXEC, DONE; all outputs registered.
- IDLE:
  - If any req_valid is high, select the first set bit searching ptr+1, ptr+2, ... modulo NREQ.
  - Latch the winner's index, op and data; set grant one-hot; go to EXEC.
  - If no req_valid is high, stay in IDLE with grant=0.
- EXEC (one cycle):
  - At the clock edge, q is updated from the latched op: 00 -> data, 01 -> all zeros, 10 -> all ones, 11 -> unchanged.
  - Go to DONE and assert req_ack[owner].
- DONE (one cycle):
  - req_ack[owner]=1.
  - At the edge: ptr<=owner, last_owner<=owner, grant<=0, req_ack<=0, go to IDLE.
- Latency: request sampled at edge E0; q updated at E1; ack high E1->E2; next arbitration at E3 at the earliest. Each transaction occupies 3 cycles.
- Requester rules:
  - Hold req_valid, req_op and req_data stable until the request is granted.
  - Op and data are latched at E0; changes afterwards are ignored.
  - Deassert req_valid at the edge where the ack is sampled high (E2); otherwise the request is served again.
- Fairness: all NREQ valid continuously gives service order 0,1,...,NREQ-1,0,...; no requester waits more than NREQ transactions.
- Changes to req_valid during EXEC/DONE have no effect until the next IDLE.
- Wrap-around: ptr=NREQ-1 searches from 0.
- Reset mid-operation: aclr in EXEC or DONE aborts the transaction. No ack is issued, q=0, ptr resets. The requester keeps req_valid and is re-arbitrated after reset release.
- Undefined op encodings cannot occur (2-bit field fully decoded).

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined:
  - Adds input req_lock (NREQ bits).
  - If req_lock[owner]=1 during DONE, the owner is marked locked.
  - In the next IDLE, a locked owner with req_valid high is granted unconditionally, ignoring round-robin.
  - The lock is released when the owner's req_lock is low in DONE, or when the owner's req_valid is low in IDLE; normal round-robin then resumes from ptr=owner.
  - aclr clears the lock.
- Not defined: port absent, pure round-robin, no lock state.

Test Plan:
- Reset: aclr=1 mid-cycle -> immediately q=0x00, grant=0, busy=0, last_owner=3; after release with no requests, all outputs hold.
- Single load: req_valid=0001, op0=00, data0=0xA5 -> grant=0001 at E0, q=0xA5 after E1, req_ack=0001 for exactly one cycle, last_owner=0.
- Clear/preset/read: requester 2 presets (q=0xFF), requester 1 clears (q=0x00), requester 3 no-op read (q stays 0x00, ack still pulses once).
- Fairness: req_valid=1111 held, each requester drops on ack and re-asserts -> ack order 0,1,2,3,0,1; each transaction 3 cycles.
- Abort: aclr pulsed during EXEC of requester 2 loading 0x3C -> q=0x00, no ack; after release, requester 2 (still valid) is served and q=0x3C.
- ARB_LOCK_EN: requester 1 locked with 3 back-to-back loads while req_valid=1111 -> grants 1,1,1; then req_lock low -> next grants 2,3,0.
